// File: rtl/bist_and_sequencer.sv
// Session sequencer for the 2-input AND BIST datapath.
// Drives init -> en (PATTERN_COUNT cycles) -> compare, then latches the
// comparator verdict and holds done/pass_fail until the next session.
module bist_and_sequencer #(
    parameter int PATTERN_COUNT = 3,
    parameter int CNT_W         = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start_BIST,
    input  logic             abort,
    input  logic             result,
    output logic             init,
    output logic             en,
    output logic             compare,
    output logic             busy,
    output logic             done,
    output logic             pass_fail,
    output logic [CNT_W-1:0] pat_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_CMP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // One extra counter bit so PATTERN_COUNT == 2**CNT_W is representable.
    localparam logic [CNT_W:0] PC_MAX  = (CNT_W+1)'(PATTERN_COUNT);
    localparam logic [CNT_W:0] PC_LAST = (CNT_W+1)'(PATTERN_COUNT - 1);

    logic [2:0]     state_q, state_d;
    logic           start_q;
    logic [CNT_W:0] cnt_q, cnt_d;
    logic           pf_q, pf_d;
    logic           start_edge;
    logic           in_session;

    assign start_edge = Start_BIST & ~start_q;
    assign in_session = (state_q == S_INIT) || (state_q == S_RUN) || (state_q == S_CMP);

    // Next-state logic; abort overrides everything while a session is active.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pf_d    = pf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // abort coinciding with the edge swallows the edge
                if (start_edge && !abort) state_d = S_INIT;
            end
            S_INIT: begin
                cnt_d   = '0;
                pf_d    = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt_q < PC_MAX) cnt_d = cnt_q + 1'b1;
                if (cnt_q == PC_LAST) state_d = S_CMP;
            end
            S_CMP: begin
                pf_d    = result;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort && in_session) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pf_d    = 1'b0;
        end
    end

    // State, counter, verdict and start edge-detect registers.
    // start_q resets high so a Start_BIST held through reset does not fire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            start_q <= 1'b1;
            cnt_q   <= '0;
            pf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= Start_BIST;
            cnt_q   <= cnt_d;
            pf_q    <= pf_d;
        end
    end

    // Moore decode: control outputs depend on the state register only.
    assign init      = (state_q == S_INIT);
    assign en        = (state_q == S_RUN);
    assign compare   = (state_q == S_CMP);
    assign busy      = in_session;
    assign done      = (state_q == S_DONE);
    assign pass_fail = pf_q;
    // Count of 2**CNT_W does not fit the port; show it as all ones.
    assign pat_cnt   = cnt_q[CNT_W] ? {CNT_W{1'b1}} : cnt_q[CNT_W-1:0];

endmodule

// File: tb/tb_bist_and_sequencer.sv
// Randomized bench for bist_and_sequencer: two builds (PATTERN_COUNT 3 and 1)
// share stimulus and are checked against a session-timeline model.
module tb_bist_and_sequencer;

    logic clk = 1'b0;
    logic rst, Start_BIST, abort, result;

    logic       init3, en3, cmp3, busy3, done3, pf3;
    logic [1:0] cnt3;
    logic       init1, en1, cmp1, busy1, done1, pf1;
    logic [1:0] cnt1;

    always #5 clk = ~clk;

    bist_and_sequencer #(.PATTERN_COUNT(3), .CNT_W(2)) u_dut3 (
        .clk(clk), .rst(rst), .Start_BIST(Start_BIST), .abort(abort), .result(result),
        .init(init3), .en(en3), .compare(cmp3), .busy(busy3), .done(done3),
        .pass_fail(pf3), .pat_cnt(cnt3)
    );

    bist_and_sequencer #(.PATTERN_COUNT(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .Start_BIST(Start_BIST), .abort(abort), .result(result),
        .init(init1), .en(en1), .compare(cmp1), .busy(busy1), .done(done1),
        .pass_fail(pf1), .pat_cnt(cnt1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: t = cycle index within the session (-1 when no session).
    // t==0 init, 1..P en, P+1 compare.
    int pcs  [2] = '{3, 1};
    int mt   [2];
    int mcnt [2];
    int mpf  [2];
    int mfin [2];
    int sprev;
    int sessions_done = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mt[k] = -1; mcnt[k] = 0; mpf[k] = 0; mfin[k] = 0;
        end
        sprev = 1;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        int edge_seen;
        edge_seen = (Start_BIST == 1'b1) && (sprev == 0);
        sprev = int'(Start_BIST);
        for (int k = 0; k < 2; k++) begin
            if (mt[k] >= 0) begin
                if (abort) begin
                    mt[k] = -1; mcnt[k] = 0; mpf[k] = 0; mfin[k] = 0;
                end else if (mt[k] == 0) begin
                    mcnt[k] = 0; mpf[k] = 0; mt[k] = 1;
                end else if (mt[k] <= pcs[k]) begin
                    mcnt[k] = (mcnt[k] + 1 > pcs[k]) ? pcs[k] : mcnt[k] + 1;
                    mt[k]++;
                end else begin
                    mpf[k] = int'(result); mfin[k] = 1; mt[k] = -1;
                    if (k == 0) sessions_done++;
                end
            end else if (edge_seen && !abort) begin
                mt[k] = 0; mfin[k] = 0;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            int t, p;
            logic [7:0] o;
            t = mt[k]; p = pcs[k];
            o = (k == 0) ? {init3, en3, cmp3, busy3, done3, pf3, cnt3}
                         : {init1, en1, cmp1, busy1, done1, pf1, cnt1};
            chk($sformatf("init[P%0d]", p),      int'(o[7]),   int'(t == 0));
            chk($sformatf("en[P%0d]", p),        int'(o[6]),   int'(t >= 1 && t <= p));
            chk($sformatf("compare[P%0d]", p),   int'(o[5]),   int'(t == p + 1));
            chk($sformatf("busy[P%0d]", p),      int'(o[4]),   int'(t >= 0));
            chk($sformatf("done[P%0d]", p),      int'(o[3]),   mfin[k]);
            chk($sformatf("pass_fail[P%0d]", p), int'(o[2]),   mpf[k]);
            chk($sformatf("pat_cnt[P%0d]", p),   int'(o[1:0]), mcnt[k]);
        end
    endtask

    // One clock: check at the falling edge, drive, optionally pulse async reset.
    task automatic cycle(input logic sb, input logic ab, input logic res, input bit do_rst);
        @(negedge clk);
        check_all();
        Start_BIST = sb; abort = ab; result = res;
        if (do_rst) begin
            #2 rst = 1'b1;
            #1 model_reset();
            check_all();
            #1 rst = 1'b0;
        end
        @(posedge clk);
        model_step();
    endtask

    initial begin
        logic sb;
        rst = 1'b1; Start_BIST = 1'b1; abort = 1'b0; result = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;

        // Start held high across reset release: no session
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        // Clean passing session then a failing one with Start_BIST left high
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (10) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (12) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        // Abort in second RUN cycle, then a fresh session
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (8) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        // Re-edge during RUN is ignored
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (6) cycle(1'b1, 1'b0, 1'b1, 1'b0);

        // Randomized phase
        sb = Start_BIST;
        for (int i = 0; i < 4000; i++) begin
            bit do_rst;
            if ($urandom_range(0, 3) == 0) sb = ~sb;
            do_rst = (mt[0] == pcs[0] + 1 && $urandom_range(0, 3) == 0) ||
                     ($urandom_range(0, 299) == 0);
            cycle(sb, ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), do_rst);
        end

        if (sessions_done < 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL session_coverage: got %0d expected at least 20", sessions_done);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
